// File: rtl/key_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_evt_pkg
// Purpose  : Event codes and gesture-FSM state encoding shared by the key
//            event controller and its output buffer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package key_evt_pkg;

  localparam logic [2:0] EVT_NONE        = 3'd0;
  localparam logic [2:0] EVT_CLICK       = 3'd1;
  localparam logic [2:0] EVT_DOUBLE      = 3'd2;
  localparam logic [2:0] EVT_LONG_START  = 3'd3;
  localparam logic [2:0] EVT_LONG_REPEAT = 3'd4;
  localparam logic [2:0] EVT_LONG_END    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } state_t;

endpackage : key_evt_pkg
`default_nettype wire

// File: rtl/key_evt_buf.sv
`default_nettype none
// ============================================================================
// Module   : key_evt_buf
// Purpose  : One-deep valid/ready event register with a sticky overflow flag.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            push, push_code - new event request and its code
//            evt_ready       - consumer accepts the held event
//            ovf_clr         - clears the sticky overflow flag
//            evt_valid       - an unread event is held
//            evt_code        - held event code (EVT_NONE when empty)
//            ovf             - sticky: an event was dropped
// Revision : 1.0 - initial release
// ============================================================================
module key_evt_buf
  import key_evt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [2:0] push_code,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       ovf
);

  logic accept;
  logic drop;

  assign accept = evt_valid & evt_ready;
  // The slot is free either when empty or when it is being read this cycle.
  assign drop   = push & evt_valid & ~evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_code  <= EVT_NONE;
    end else if (push && !drop) begin
      evt_valid <= 1'b1;
      evt_code  <= push_code;
    end else if (accept) begin
      evt_valid <= 1'b0;
      evt_code  <= EVT_NONE;
    end
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule : key_evt_buf
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ctrl
// Purpose  : Gesture classifier behind a debounced key. Turns key_flag /
//            key_state into CLICK, DOUBLE, LONG_START, LONG_REPEAT and
//            LONG_END events delivered through a one-deep valid/ready buffer.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            en                  - enable; low forces IDLE
//            key_flag, key_state - debounced edge pulse and level (0=pressed)
//            evt_valid, evt_code - event output register
//            evt_ready           - consumer accepts the event
//            ovf, ovf_clr        - sticky drop flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int LONG_CYC   = 25_000_000,
  parameter int DCLK_CYC   = 12_500_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int CNT_W      = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       key_flag,
  input  logic       key_state,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  input  logic       evt_ready,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLK_LAST   = CNT_W'(DCLK_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             press;
  logic             release_evt;
  logic             push;
  logic [2:0]       push_code;

  assign press       = key_flag & ~key_state;
  assign release_evt = key_flag &  key_state;

  // Gesture FSM and timer. Key edges are tested before timeouts so an edge
  // always wins a same-cycle tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
    end else if (!en) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
      case (state)
        ST_IDLE: begin
          if (press) begin
            state <= ST_PRESS1;
            timer <= '0;
          end
        end
        ST_PRESS1: begin
          if (release_evt) begin
            state <= ST_WAIT2;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state <= ST_LONG;
            timer <= '0;
          end
        end
        ST_WAIT2: begin
          if (press) begin
            state <= ST_PRESS2;
            timer <= '0;
          end else if (timer == DCLK_LAST) begin
            state <= ST_IDLE;
            timer <= '0;
          end
        end
        ST_PRESS2: begin
          if (release_evt) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state <= ST_LONG;
            timer <= '0;
          end
        end
        ST_LONG: begin
          if (release_evt) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (timer == REPEAT_LAST) begin
            timer <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // Event request in the triggering cycle; the buffer registers it, giving
  // one cycle of latency to evt_valid/evt_code.
  always_comb begin
    push      = 1'b0;
    push_code = EVT_NONE;
    if (en) begin
      case (state)
        ST_PRESS1: begin
          if (!release_evt && timer == LONG_LAST) begin
            push      = 1'b1;
            push_code = EVT_LONG_START;
          end
        end
        ST_WAIT2: begin
          if (!press && timer == DCLK_LAST) begin
            push      = 1'b1;
            push_code = EVT_CLICK;
          end
        end
        ST_PRESS2: begin
          if (release_evt) begin
            push      = 1'b1;
            push_code = EVT_DOUBLE;
          end else if (timer == LONG_LAST) begin
            push      = 1'b1;
            push_code = EVT_LONG_START;
          end
        end
        ST_LONG: begin
          if (release_evt) begin
            push      = 1'b1;
            push_code = EVT_LONG_END;
          end else if (timer == REPEAT_LAST) begin
            push      = 1'b1;
            push_code = EVT_LONG_REPEAT;
          end
        end
        default: begin
          push      = 1'b0;
          push_code = EVT_NONE;
        end
      endcase
    end
  end

  key_evt_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_code (push_code),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .ovf       (ovf)
  );

endmodule : key_event_ctrl
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_ctrl
// Purpose  : Directed self-checking bench for key_event_ctrl with
//            LONG_CYC=100, DCLK_CYC=40, REPEAT_CYC=20.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       key_flag;
  logic       key_state;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_ready;
  logic       ovf;
  logic       ovf_clr;

  int n_cmp = 0;
  int n_err = 0;
  int seen;

  key_event_ctrl #(
    .LONG_CYC   (100),
    .DCLK_CYC   (40),
    .REPEAT_CYC (20),
    .CNT_W      (25)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .key_flag  (key_flag),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Advance n clock edges; inputs change and outputs are sampled 1 ns after.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle key_flag pulse with the given level (0 = press, 1 = release).
  task automatic pulse(input logic lvl);
    key_state = lvl;
    key_flag  = 1'b1;
    tick(1);
    key_flag  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tick n cycles and count cycles in which evt_valid was seen high.
  task automatic watch(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick(1);
      if (evt_valid) cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; key_flag = 1'b0; key_state = 1'b1;
    evt_ready = 1'b1; ovf_clr = 1'b0;
    tick(2);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_code",  32'(evt_code),  32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    rst = 1'b0;
    tick(2);

    // Click: CLICK appears 40 edges after the release edge.
    pulse(1'b0);
    tick(29);
    pulse(1'b1);
    tick(39);
    chk("click_early", 32'(evt_valid), 32'd0);
    tick(1);
    chk("click_valid", 32'(evt_valid), 32'd1);
    chk("click_code",  32'(evt_code),  32'd1);
    tick(1);
    chk("click_clear", 32'(evt_valid), 32'd0);
    tick(5);

    // Double click.
    pulse(1'b0);
    tick(9);
    pulse(1'b1);
    tick(19);
    pulse(1'b0);
    tick(9);
    chk("dbl_early", 32'(evt_valid), 32'd0);
    pulse(1'b1);
    chk("dbl_valid", 32'(evt_valid), 32'd1);
    chk("dbl_code",  32'(evt_code),  32'd2);
    watch(60, seen);
    chk("dbl_no_click", 32'(seen), 32'd0);

    // Long press held 165 cycles.
    pulse(1'b0);
    tick(99);
    chk("long_early", 32'(evt_valid), 32'd0);
    tick(1);
    chk("long_start", 32'(evt_code), 32'd3);
    for (int r = 0; r < 3; r++) begin
      tick(19);
      chk("rep_early", 32'(evt_valid), 32'd0);
      tick(1);
      chk("rep_code", 32'(evt_code), 32'd4);
    end
    tick(4);
    pulse(1'b1);
    chk("long_end", 32'(evt_code), 32'd5);
    tick(1);
    chk("long_end_clear", 32'(evt_valid), 32'd0);
    tick(5);

    // Tie in WAIT2: press on timer==39 beats the click timeout.
    pulse(1'b0);
    tick(5);
    pulse(1'b1);
    tick(39);
    pulse(1'b0);
    chk("tie_no_click", 32'(evt_valid), 32'd0);
    tick(5);
    pulse(1'b1);
    chk("tie_double", 32'(evt_code), 32'd2);
    tick(5);

    // Backpressure: second click dropped, first held, ovf set.
    evt_ready = 1'b0;
    pulse(1'b0); tick(5); pulse(1'b1); tick(40);
    chk("bp_first", 32'(evt_code), 32'd1);
    pulse(1'b0); tick(5); pulse(1'b1); tick(40);
    chk("bp_held_valid", 32'(evt_valid), 32'd1);
    chk("bp_held_code",  32'(evt_code),  32'd1);
    chk("bp_ovf",        32'(ovf),       32'd1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("bp_accept", 32'(evt_valid), 32'd0);
    chk("bp_ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("bp_ovf_clr", 32'(ovf), 32'd0);

    // Reset mid-LONG with LONG_START held: async clear, no LONG_END later.
    pulse(1'b0);
    tick(110);
    chk("rst_pre_held", 32'(evt_code), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(evt_valid), 32'd0);
    chk("rst_async_code",  32'(evt_code),  32'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    pulse(1'b1);
    watch(10, seen);
    chk("rst_no_long_end", 32'(seen), 32'd0);

    // Enable drop mid-PRESS1 with a held CLICK.
    pulse(1'b0); tick(5); pulse(1'b1); tick(40);
    chk("en_held", 32'(evt_code), 32'd1);
    pulse(1'b0);
    tick(10);
    en = 1'b0;
    tick(120);
    chk("en_keep_code", 32'(evt_code), 32'd1);
    chk("en_no_ovf",    32'(ovf),      32'd0);
    en = 1'b1;
    pulse(1'b1);
    tick(60);
    chk("en_idle_code", 32'(evt_code), 32'd1);
    chk("en_idle_ovf",  32'(ovf),      32'd0);
    evt_ready = 1'b1;
    tick(1);
    chk("en_read", 32'(evt_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_key_event_ctrl
`default_nettype wire

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Gesture controller behind a debounced key.
- Consumes the debouncer's one-cycle key_flag pulse and its key_state level (1 = released, 0 = pressed).
- Classifies each gesture as click, double-click, long-press start, long-press repeat or long-press end.
- Emits one event code at a time through a one-deep valid/ready output register read by the UI/menu logic.

Parameters:
- LONG_CYC, 25_000_000: hold time in clk cycles before a press counts as long (500 ms at 50 MHz).
- DCLK_CYC, 12_500_000: maximum release gap in cycles for a second press to form a double-click.
- REPEAT_CYC, 5_000_000: period in cycles of repeat events while a long press is held.
- CNT_W, 25: timer width; must hold max(LONG_CYC, DCLK_CYC, REPEAT_CYC).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous reset, active-high
- en  in  1  controller enable; low forces IDLE
- key_flag  in  1  one-cycle pulse on each debounced edge
- key_state  in  1  debounced level; 0 = pressed, 1 = released
- evt_valid  out  1  event register holds an unread event
- evt_code  out  3  1 CLICK, 2 DOUBLE, 3 LONG_START, 4 LONG_REPEAT, 5 LONG_END; 0 when none
- evt_ready  in  1  consumer accepts the event
- ovf  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset (async, active-high):
  - state IDLE, timer 0, evt_valid 0, evt_code 0, ovf 0.
- Edge decode:
  - press = key_flag & ~key_state.
  - release = key_flag & key_state.
- States and transitions (timer clears on every state entry, increments every cycle otherwise):
  - IDLE: press -> PRESS1.
  - PRESS1: release -> WAIT2. Timer == LONG_CYC-1 -> emit LONG_START, go to LONG.
  - WAIT2: press -> PRESS2. Timer == DCLK_CYC-1 -> emit CLICK, go to IDLE.
  - PRESS2: release -> emit DOUBLE, go to IDLE. Timer == LONG_CYC-1 -> emit LONG_START, go to LONG; the pending first click is discarded.
  - LONG: timer == REPEAT_CYC-1 -> emit LONG_REPEAT and clear the timer. Release -> emit LONG_END, go to IDLE.
- Simultaneous events: a key edge always wins over a timeout in the same cycle.
  - WAIT2 press + timeout: go to PRESS2, no CLICK.
  - PRESS1 release + long timeout: go to WAIT2, no LONG_START.
  - LONG release + repeat: LONG_END only.
- Ignored inputs:
  - press in LONG/PRESS1/PRESS2 and release in IDLE/WAIT2 are ignored; the debouncer guarantees alternation.
- Latency:
  - evt_valid/evt_code are registered and asserted the cycle after the triggering flag or timeout cycle.
- Output register:
  - Holds evt_valid and evt_code until the cycle with evt_valid & evt_ready; both clear after that cycle.
  - New event with evt_valid & ~evt_ready: the new event is dropped, the held event is kept, ovf is set.
  - New event in the same cycle as accept (evt_valid & evt_ready): the new event loads, nothing is dropped.
  - ovf_clr clears ovf; if a drop occurs in the same cycle, set wins.
- en low:
  - Next cycle: state IDLE, timer 0, no new events.
  - The output register and ovf are unaffected, so a held event can still be read.
- Reset mid-gesture: everything returns to reset values immediately; no LONG_END is emitted.

Decomposition:
- Shared package key_evt_pkg holds:
  - event code localparams EVT_NONE/CLICK/DOUBLE/LONG_START/LONG_REPEAT/LONG_END;
  - the state encoding IDLE/PRESS1/WAIT2/PRESS2/LONG.
- One sub-module, key_evt_buf: the one-deep valid/ready event register plus ovf logic.
- The gesture FSM and timer stay in key_event_ctrl.

Test Plan:
All scenarios use LONG_CYC=100, DCLK_CYC=40, REPEAT_CYC=20.
- Click: press, release after 30 cycles, no further press, evt_ready=1 -> one CLICK (code 1), valid exactly 40 cycles after release + 1.
- Double: press, release after 10, press 20 cycles later, release after 10 -> one DOUBLE (2) the cycle after the second release; no CLICK.
- Long: press held 165 cycles then release -> LONG_START at 100+1, LONG_REPEAT at 120+1, 140+1 and 160+1, then LONG_END after release.
- Tie: in WAIT2, press lands on timer == 39 -> no CLICK; FSM in PRESS2; a release then yields DOUBLE.
- Backpressure: evt_ready=0, two clicks in sequence -> first CLICK held, second dropped, ovf=1. Then evt_ready=1 for one cycle -> evt_valid=0. Then ovf_clr -> ovf=0.
- Reset/enable: assert rst mid-LONG -> outputs 0 asynchronously, no LONG_END. Drop en mid-PRESS1 -> IDLE, no events; a held event survives.
